// File: rtl/dac_spi_cfg_seq_if.sv
// Table-read and 4-wire SPI bus between the DAC configuration sequencer and its peers.
//   TBL_IDX  : table read index (sequencer -> table)
//   TBL_WORD : table entry, registered one cycle after TBL_IDX (table -> sequencer)
//   SPI_CSN  : chip select, active low (sequencer -> DAC)
//   SPI_SCLK : serial clock, idle low (sequencer -> DAC)
//   SPI_SDIO : serial data to the DAC, MSB first (sequencer -> DAC)
//   SPI_SDO  : serial data from the DAC (DAC -> sequencer)
interface dac_spi_cfg_seq_if #(
  parameter int unsigned IDX_W = 5
);
  logic [IDX_W-1:0] TBL_IDX;
  logic [15:0]      TBL_WORD;
  logic             SPI_CSN;
  logic             SPI_SCLK;
  logic             SPI_SDIO;
  logic             SPI_SDO;

  modport master (
    output TBL_IDX, SPI_CSN, SPI_SCLK, SPI_SDIO,
    input  TBL_WORD, SPI_SDO
  );

  modport slave (
    input  TBL_IDX, SPI_CSN, SPI_SCLK, SPI_SDIO,
    output TBL_WORD, SPI_SDO
  );
endinterface

// File: rtl/dac_spi_cfg_seq.sv
// DAC register configuration sequencer: on a rising edge of dac_set it walks an
// external table of N_REGS entries, writes each one over SPI and optionally reads
// it back to verify, retrying up to MAX_RETRY times before flagging an error.
//   DAC_CLK_120M : clock, all logic on posedge
//   SYS_RST      : asynchronous active-high reset
//   dac_set      : start request (rising edge)
//   bus          : table read port and SPI pins (master side)
//   CFG_BUSY     : sequence in progress
//   CFG_DONE     : sticky, all entries written/verified
//   CFG_ERR      : sticky, verify failed after retries
//   ERR_IDX      : failing entry index, valid while CFG_ERR=1
module dac_spi_cfg_seq #(
  parameter int unsigned N_REGS    = 16,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 DAC_CLK_120M,
  input  logic                 SYS_RST,
  input  logic                 dac_set,
  dac_spi_cfg_seq_if.master    bus,
  output logic                 CFG_BUSY,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR,
  output logic [IDX_W-1:0]     ERR_IDX
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned SEG_W   = 6;
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  // Segment 0 = setup, 1..32 = SCLK half periods (odd low, even high), 33 = hold.
  localparam logic [SEG_W-1:0] SEG_HOLD = SEG_W'(33);
  localparam logic [SEG_W-1:0] SEG_LAST_HALF = SEG_W'(32);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_GAP_W, S_RD, S_GAP_R, S_CHECK, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEG_W-1:0] seg, seg_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic             dac_set_d;
  logic             ent_vfy, ent_vfy_nxt;
  logic [6:0]       ent_addr, ent_addr_nxt;
  logic [7:0]       ent_data, ent_data_nxt;
  logic [7:0]       rd_sh, rd_sh_nxt;
  logic [IDX_W-1:0] tbl_idx, tbl_idx_nxt;
  logic             csn, csn_nxt;
  logic             sclk, sclk_nxt;
  logic             sdio, sdio_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             err, err_nxt;
  logic [IDX_W-1:0] err_idx, err_idx_nxt;

  logic             start_c;
  logic             is_rd_c;
  logic [15:0]      frame_c;
  logic [SEG_W-1:0] seg_inc_c;
  logic [3:0]       bit_c;

  assign start_c   = dac_set & ~dac_set_d;
  assign is_rd_c   = (state == S_RD);
  assign frame_c   = {is_rd_c, ent_addr, is_rd_c ? 8'h00 : ent_data};
  assign seg_inc_c = seg + SEG_W'(1);
  assign bit_c     = 4'((seg_inc_c - SEG_W'(1)) >> 1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    seg_nxt      = seg;
    retry_nxt    = retry;
    ent_vfy_nxt  = ent_vfy;
    ent_addr_nxt = ent_addr;
    ent_data_nxt = ent_data;
    rd_sh_nxt    = rd_sh;
    tbl_idx_nxt  = tbl_idx;
    csn_nxt      = csn;
    sclk_nxt     = sclk;
    sdio_nxt     = sdio;
    busy_nxt     = busy;
    done_nxt     = done;
    err_nxt      = err;
    err_idx_nxt  = err_idx;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_c) begin
          state_nxt   = S_FETCH;
          cnt_nxt     = '0;
          retry_nxt   = '0;
          tbl_idx_nxt = '0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          err_nxt     = 1'b0;
        end
      end

      // First cycle lets the table register the new index; the word is captured on the second.
      S_FETCH: begin
        if (cnt == '0) begin
          cnt_nxt = CNT_W'(1);
        end else begin
          ent_vfy_nxt  = bus.TBL_WORD[15];
          ent_addr_nxt = bus.TBL_WORD[14:8];
          ent_data_nxt = bus.TBL_WORD[7:0];
          state_nxt    = S_WR;
          cnt_nxt      = '0;
          seg_nxt      = '0;
          csn_nxt      = 1'b0;
          sclk_nxt     = 1'b0;
          sdio_nxt     = 1'b0;
        end
      end

      // Frame engine: each segment lasts CLK_DIV cycles.
      S_WR, S_RD: begin
        if (cnt != DIV_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          if (seg == SEG_HOLD) begin
            state_nxt = is_rd_c ? S_GAP_R : S_GAP_W;
            seg_nxt   = '0;
            csn_nxt   = 1'b1;
            sclk_nxt  = 1'b0;
            sdio_nxt  = 1'b0;
          end else begin
            seg_nxt  = seg_inc_c;
            sclk_nxt = (seg_inc_c <= SEG_LAST_HALF) && !seg_inc_c[0];
            if (seg_inc_c[0] && (seg_inc_c < SEG_LAST_HALF)) begin
              sdio_nxt = frame_c[4'd15 - bit_c];
            end
            // Capture read data on the edge that raises SCLK for bits 7..0.
            if (is_rd_c && !seg_inc_c[0] && (seg_inc_c <= SEG_LAST_HALF) && (bit_c >= 4'd8)) begin
              rd_sh_nxt = {rd_sh[6:0], bus.SPI_SDO};
            end
          end
        end
      end

      S_GAP_W: begin
        if (cnt != GAP_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          if (ent_vfy) begin
            state_nxt = S_RD;
            seg_nxt   = '0;
            csn_nxt   = 1'b0;
            sclk_nxt  = 1'b0;
            sdio_nxt  = 1'b1;
          end else begin
            state_nxt = S_NEXT;
          end
        end
      end

      S_GAP_R: begin
        if (cnt != GAP_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
          state_nxt = S_CHECK;
        end
      end

      // Retry reuses the latched entry without a re-fetch.
      S_CHECK: begin
        if (rd_sh == ent_data) begin
          state_nxt = S_NEXT;
        end else if (retry < RTY_MAX) begin
          retry_nxt = retry + RTY_W'(1);
          state_nxt = S_WR;
          cnt_nxt   = '0;
          seg_nxt   = '0;
          csn_nxt   = 1'b0;
          sclk_nxt  = 1'b0;
          sdio_nxt  = 1'b0;
        end else begin
          state_nxt   = S_ERROR;
          err_nxt     = 1'b1;
          err_idx_nxt = tbl_idx;
          busy_nxt    = 1'b0;
        end
      end

      S_NEXT: begin
        retry_nxt = '0;
        if (tbl_idx == LAST_IDX) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          tbl_idx_nxt = tbl_idx + IDX_W'(1);
          cnt_nxt     = '0;
          state_nxt   = S_FETCH;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge DAC_CLK_120M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seg       <= '0;
      retry     <= '0;
      dac_set_d <= 1'b0;
      ent_vfy   <= 1'b0;
      ent_addr  <= '0;
      ent_data  <= '0;
      rd_sh     <= '0;
      tbl_idx   <= '0;
      csn       <= 1'b1;
      sclk      <= 1'b0;
      sdio      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      seg       <= seg_nxt;
      retry     <= retry_nxt;
      dac_set_d <= dac_set;
      ent_vfy   <= ent_vfy_nxt;
      ent_addr  <= ent_addr_nxt;
      ent_data  <= ent_data_nxt;
      rd_sh     <= rd_sh_nxt;
      tbl_idx   <= tbl_idx_nxt;
      csn       <= csn_nxt;
      sclk      <= sclk_nxt;
      sdio      <= sdio_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      err_idx   <= err_idx_nxt;
    end
  end

  assign bus.TBL_IDX  = tbl_idx;
  assign bus.SPI_CSN  = csn;
  assign bus.SPI_SCLK = sclk;
  assign bus.SPI_SDIO = sdio;
  assign CFG_BUSY     = busy;
  assign CFG_DONE     = done;
  assign CFG_ERR      = err;
  assign ERR_IDX      = err_idx;

endmodule

// File: tb/tb_dac_spi_cfg_seq.sv
// Self-checking bench for dac_spi_cfg_seq: registered table model, a DAC model that
// stores writes and answers reads (with programmable corruption), a frame monitor,
// and a sequential reference model of the expected frame list and final status.
module tb_dac_spi_cfg_seq;
  localparam int unsigned N_REGS    = 3;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned GAP_CYC   = 8;
  localparam int unsigned MAX_RETRY = 2;
  localparam int FRAME_LEN = 34 * CLK_DIV;

  logic clk = 1'b0;
  logic rst;
  logic dac_set = 1'b0;
  logic cfg_busy, cfg_done, cfg_err;
  logic [IDX_W-1:0] err_idx;

  dac_spi_cfg_seq_if #(.IDX_W(IDX_W)) bus ();

  dac_spi_cfg_seq #(
    .N_REGS(N_REGS), .IDX_W(IDX_W), .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .DAC_CLK_120M(clk), .SYS_RST(rst), .dac_set(dac_set), .bus(bus),
    .CFG_BUSY(cfg_busy), .CFG_DONE(cfg_done), .CFG_ERR(cfg_err), .ERR_IDX(err_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered table, one cycle of latency from TBL_IDX.
  logic [15:0] rom [32];
  logic [15:0] tbl_word_q = 16'h0000;
  always @(posedge clk) tbl_word_q <= rom[bus.TBL_IDX];
  assign bus.TBL_WORD = tbl_word_q;

  // DAC model state and read-corruption policy (bad_cnt: 0 none, >0 remaining, -1 always).
  logic [7:0] dac_regs [128];
  logic [7:0] bad_val  [128];
  int         bad_cnt  [128];

  function automatic logic [7:0] dac_reply(input logic [6:0] a);
    if (bad_cnt[a] != 0) begin
      if (bad_cnt[a] > 0) bad_cnt[a]--;
      return bad_val[a];
    end
    return dac_regs[a];
  endfunction

  // Frame monitor and SDO driver, sampled on the falling clock edge.
  logic sdo_drv = 1'b0;
  assign bus.SPI_SDO = sdo_drv;
  logic csn_p = 1'b1, sclk_p = 1'b0, sdio_p = 1'b0;
  int low_cnt = 0, high_cnt = 1000, rises = 0;
  logic [15:0] shift = '0, resp = '0;
  logic [15:0] obs_q [$];
  int shape_bad = 0, gap_bad = 0, sdio_bad = 0;

  always @(negedge clk) begin
    if (bus.SPI_CSN === 1'b0) begin
      if (csn_p) begin
        if (high_cnt < int'(GAP_CYC)) gap_bad++;
        low_cnt = 0; rises = 0; shift = '0; resp = '0;
      end
      low_cnt++;
      if (bus.SPI_SCLK && !sclk_p) begin
        shift = {shift[14:0], bus.SPI_SDIO};
        rises++;
        if (rises == 8 && shift[7]) resp = {8'h00, dac_reply(shift[6:0])};
      end
      if (bus.SPI_SCLK && sclk_p && (bus.SPI_SDIO !== sdio_p)) sdio_bad++;
      if (!bus.SPI_SCLK && sclk_p)
        sdo_drv = (rises >= 8 && rises < 16) ? resp[4'(15 - rises)] : 1'b0;
    end else begin
      if (!csn_p) begin
        obs_q.push_back(shift);
        if (low_cnt != FRAME_LEN || rises != 16) shape_bad++;
        if (!shift[15]) dac_regs[shift[14:8]] = shift[7:0];
        high_cnt = 0;
        sdo_drv = 1'b0;
      end
      high_cnt++;
    end
    csn_p  = (bus.SPI_CSN !== 1'b0);
    sclk_p = bus.SPI_SCLK;
    sdio_p = bus.SPI_SDIO;
  end

  // Reference model: expected frames and final status from the table and DAC policy.
  logic [15:0] exp_q [$];
  bit exp_done, exp_err;
  int exp_err_idx, exp_last_idx;
  int m_bad_cnt [128];

  task automatic model_run();
    exp_q.delete();
    exp_err = 0; exp_err_idx = 0; exp_last_idx = 0;
    for (int a = 0; a < 128; a++) m_bad_cnt[a] = bad_cnt[a];
    for (int i = 0; i < int'(N_REGS) && !exp_err; i++) begin
      logic [15:0] e;
      logic [7:0] rd;
      int tries;
      bit fin;
      e = rom[i]; tries = 0; fin = 0;
      while (!fin) begin
        exp_q.push_back({1'b0, e[14:0]});
        if (!e[15]) begin
          fin = 1;
        end else begin
          exp_q.push_back({1'b1, e[14:8], 8'h00});
          if (m_bad_cnt[e[14:8]] != 0) begin
            rd = bad_val[e[14:8]];
            if (m_bad_cnt[e[14:8]] > 0) m_bad_cnt[e[14:8]]--;
          end else begin
            rd = e[7:0];
          end
          if (rd == e[7:0]) fin = 1;
          else if (tries == int'(MAX_RETRY)) begin exp_err = 1; exp_err_idx = i; fin = 1; end
          else tries++;
        end
      end
      exp_last_idx = i;
    end
    exp_done = !exp_err;
  endtask

  task automatic clear_policy();
    for (int a = 0; a < 128; a++) begin bad_cnt[a] = 0; bad_val[a] = 8'h00; end
  endtask

  task automatic pulse_start();
    @(negedge clk) dac_set = 1'b1;
    @(negedge clk) dac_set = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cfg_busy && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_idle_timeout"}, 32'(cfg_busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_nframes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "_shape"}, shape_bad, 0);
    check({tag, "_gap"}, gap_bad, 0);
    check({tag, "_sdio_stable"}, sdio_bad, 0);
  endtask

  task automatic cmp_status(input string tag);
    check({tag, "_done"}, 32'(cfg_done), 32'(exp_done));
    check({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    if (exp_err) check({tag, "_err_idx"}, 32'(err_idx), 32'(exp_err_idx));
    check({tag, "_tbl_idx"}, 32'(bus.TBL_IDX), 32'(exp_last_idx));
    check({tag, "_csn_high"}, 32'(bus.SPI_CSN), 32'd1);
  endtask

  typedef struct {
    logic [15:0] t0, t1, t2;
    logic [6:0]  bad_addr;
    logic [7:0]  bad_v;
    int          bad_n;
    int          n_frames;
    logic [15:0] w0, w1;
    bit          done_e, err_e;
    int          err_idx_e, last_idx_e;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [15:0] w1_act;
    logic [6:0] a;
    int k;

    vecs[0] = '{16'h0512, 16'h0634, 16'h0756, 7'h00, 8'h00,  0, 3, 16'h0512, 16'h0634, 1'b1, 1'b0, 0, 2};
    vecs[1] = '{16'h8A5C, 16'h0634, 16'h0756, 7'h00, 8'h00,  0, 4, 16'h0A5C, 16'h8A00, 1'b1, 1'b0, 0, 2};
    vecs[2] = '{16'h8A5C, 16'h0634, 16'h0756, 7'h0A, 8'h00,  1, 6, 16'h0A5C, 16'h8A00, 1'b1, 1'b0, 0, 2};
    vecs[3] = '{16'h0512, 16'h8B33, 16'h0756, 7'h0B, 8'hFF, -1, 7, 16'h0512, 16'h0B33, 1'b0, 1'b1, 1, 1};

    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 128; i++) dac_regs[i] = 8'h00;
    clear_policy();

    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(bus.SPI_CSN), 32'd1);
    check("rst_sclk", 32'(bus.SPI_SCLK), 32'd0);
    check("rst_sdio", 32'(bus.SPI_SDIO), 32'd0);
    check("rst_tbl_idx", 32'(bus.TBL_IDX), 32'd0);
    check("rst_status", {29'd0, cfg_busy, cfg_done, cfg_err}, 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed vectors.
    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      rom[0] = vecs[v].t0; rom[1] = vecs[v].t1; rom[2] = vecs[v].t2;
      clear_policy();
      bad_cnt[vecs[v].bad_addr] = vecs[v].bad_n;
      bad_val[vecs[v].bad_addr] = vecs[v].bad_v;
      model_run();
      obs_q.delete();
      pulse_start();
      check({tag, "_busy_on_start"}, {30'd0, cfg_busy, cfg_done}, 32'd2);
      check({tag, "_idx_on_start"}, 32'(bus.TBL_IDX), 32'd0);
      wait_idle(tag);
      check({tag, "_nframes_hand"}, obs_q.size(), vecs[v].n_frames);
      check({tag, "_w0_hand"}, (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx, vecs[v].w0);
      w1_act = (obs_q.size() > 1) ? obs_q[1] : 16'hxxxx;
      check({tag, "_w1_hand"}, w1_act, vecs[v].w1);
      check({tag, "_done_hand"}, 32'(cfg_done), 32'(vecs[v].done_e));
      check({tag, "_err_hand"}, 32'(cfg_err), 32'(vecs[v].err_e));
      if (vecs[v].err_e) check({tag, "_err_idx_hand"}, 32'(err_idx), 32'(vecs[v].err_idx_e));
      check({tag, "_tbl_idx_hand"}, 32'(bus.TBL_IDX), 32'(vecs[v].last_idx_e));
      cmp_frames(tag);
      cmp_status(tag);
    end

    // dac_set held high: exactly one sequence.
    rom[0] = 16'h0512; rom[1] = 16'h0634; rom[2] = 16'h0756;
    clear_policy();
    model_run();
    obs_q.delete();
    @(negedge clk) dac_set = 1'b1;
    repeat (1000) @(negedge clk);
    check("hold_busy", 32'(cfg_busy), 32'd0);
    check("hold_nframes", obs_q.size(), 3);
    cmp_status("hold");
    dac_set = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_release_nframes", obs_q.size(), 3);

    // Second rising edge while busy is ignored.
    model_run();
    obs_q.delete();
    pulse_start();
    repeat (50) @(negedge clk);
    pulse_start();
    wait_idle("busy_edge");
    cmp_frames("busy_edge");
    cmp_status("busy_edge");

    // Rising edge after DONE clears the flags and restarts from index 0.
    obs_q.delete();
    @(negedge clk) dac_set = 1'b1;
    @(negedge clk);
    check("restart_done_clr", 32'(cfg_done), 32'd0);
    check("restart_busy", 32'(cfg_busy), 32'd1);
    check("restart_idx", 32'(bus.TBL_IDX), 32'd0);
    dac_set = 1'b0;
    wait_idle("restart");
    cmp_frames("restart");
    cmp_status("restart");

    // Randomized tables and DAC misbehaviour against the reference model.
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("rand%0d", r);
      clear_policy();
      for (int i = 0; i < 3; i++) begin
        a = {5'($urandom_range(0, 31)), 2'(i)};
        rom[i] = {1'($urandom_range(0, 1)), a, 8'($urandom)};
      end
      k = $urandom_range(0, 2);
      a = rom[k][14:8];
      bad_val[a] = rom[k][7:0] ^ 8'($urandom_range(1, 255));
      bad_cnt[a] = $urandom_range(0, 3);
      model_run();
      obs_q.delete();
      pulse_start();
      wait_idle(tag);
      cmp_frames(tag);
      cmp_status(tag);
    end

    // Reset in the middle of a write frame.
    rom[0] = 16'h0512; rom[1] = 16'h0634; rom[2] = 16'h0756;
    clear_policy();
    obs_q.delete();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(rises >= 9 && bus.SPI_CSN === 1'b0) && n < 2000) begin @(negedge clk); n++; end
      check("midrst_reach_bit9", 32'(n < 2000), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_csn", 32'(bus.SPI_CSN), 32'd1);
    check("midrst_sclk", 32'(bus.SPI_SCLK), 32'd0);
    check("midrst_status", {29'd0, cfg_busy, cfg_done, cfg_err}, 32'd0);
    check("midrst_tbl_idx", 32'(bus.TBL_IDX), 32'd0);
    check("midrst_err_idx", 32'(err_idx), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs_q.delete();
    shape_bad = 0; gap_bad = 0; sdio_bad = 0;
    repeat (300) @(negedge clk);
    check("midrst_quiet_frames", obs_q.size(), 0);
    check("midrst_quiet_csn", 32'(bus.SPI_CSN), 32'd1);
    check("midrst_quiet_busy", 32'(cfg_busy), 32'd0);
    model_run();
    pulse_start();
    wait_idle("post_rst");
    cmp_frames("post_rst");
    cmp_status("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_cfg_seq.md
Name: dac_spi_cfg_seq

Overview:
Sequences the DAC register configuration over a 4-wire SPI port after clocking is stable. A rising edge on dac_set starts the sequence. The block walks a register table of N_REGS entries held externally, writes each entry, and optionally reads it back to verify it. It runs in the DAC_CLK_120M domain under SYS_RST and reports busy, done and error status to the system controller.

Parameters:
N_REGS, 16, number of table entries written per sequence (1..2^IDX_W)
IDX_W, 5, width of the table index
CLK_DIV, 4, SCLK half-period in DAC_CLK_120M cycles (>=2)
GAP_CYC, 8, minimum SPI_CSN high time between frames, in cycles
MAX_RETRY, 2, write+verify retries per entry before error

Ports:
DAC_CLK_120M  in   1      system clock; all logic on posedge
SYS_RST       in   1      asynchronous, active-high reset
dac_set       in   1      start request; rising edge detected internally
TBL_IDX       out  IDX_W  table read index
TBL_WORD      in   16     table entry; 1-cycle registered latency from TBL_IDX. [15]=verify enable, [14:8]=register address, [7:0]=register data
SPI_CSN       out  1      chip select, active low
SPI_SCLK      out  1      serial clock, idle low
SPI_SDIO      out  1      serial data to DAC, MSB first
SPI_SDO       in   1      serial data from DAC
CFG_BUSY      out  1      sequence in progress
CFG_DONE      out  1      sticky; all entries written and verified
CFG_ERR       out  1      sticky; verify failed after retries
ERR_IDX       out  IDX_W  index of the failing entry; valid while CFG_ERR=1

Behaviour:
- Reset values (asynchronous): SPI_CSN=1, SPI_SCLK=0, SPI_SDIO=0, TBL_IDX=0, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0, ERR_IDX=0, state=IDLE, retry count=0.
- Start condition: dac_set is registered once. start = dac_set & ~dac_set_d.
  - Acted on in IDLE, DONE or ERROR.
  - Ignored while CFG_BUSY=1.
  - On start: CFG_DONE=0, CFG_ERR=0, TBL_IDX=0, CFG_BUSY=1 on the next edge.
- Frame format: 16 bits, MSB first. bit15 = R/W (0=write, 1=read), bits14:8 = address, bits7:0 = data (zero on reads).
- Frame timing:
  - CSN falls, then CLK_DIV cycles of setup.
  - 16 SCLK periods, each CLK_DIV low followed by CLK_DIV high.
  - SDIO changes only while SCLK is low. SDO is sampled on the cycle SCLK rises, during bits 7..0 of a read.
  - CLK_DIV cycles of hold, then CSN rises.
  - Total CSN-low time = 34*CLK_DIV cycles. CSN then stays high for at least GAP_CYC cycles.
- States:
  - IDLE: waits for start, then goes to FETCH.
  - FETCH: one cycle for TBL_WORD to become valid; the entry is latched at the end of this cycle. Goes to WR.
  - WR: write frame using the latched address and data. Goes to GAP_W.
  - GAP_W: waits GAP_CYC cycles. If verify=1, goes to RD; otherwise goes to NEXT.
  - RD: read frame to the same address; the 8 read bits are captured into rd_data. Goes to GAP_R.
  - GAP_R: waits GAP_CYC cycles, then goes to CHECK.
  - CHECK: one cycle.
    - If rd_data == data: goes to NEXT.
    - Else if retry count < MAX_RETRY: retry count +1, goes to WR (the latched entry is reused, no re-fetch).
    - Else: goes to ERROR.
  - NEXT: clears the retry count.
    - If TBL_IDX == N_REGS-1: goes to DONE.
    - Otherwise: TBL_IDX+1, goes to FETCH.
  - DONE: CFG_DONE=1, CFG_BUSY=0.
  - ERROR: CFG_ERR=1, ERR_IDX=TBL_IDX, CFG_BUSY=0.
- Boundary rules:
  - A start in the same cycle as a CHECK failure or a NEXT decision is ignored, because CFG_BUSY=1 in that cycle.
  - TBL_IDX never wraps. It holds at N_REGS-1 in DONE and at the failing index in ERROR.
  - Reset mid-frame: SPI_CSN goes high immediately and the frame is abandoned. No partial state survives reset.
  - The entry is latched in FETCH, so a TBL_WORD change during a frame has no effect.
  - The SPI output pins are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic write sequence: N_REGS=3, CLK_DIV=4, GAP_CYC=8; table {0x0512, 0x0634, 0x0756} (verify=0). Pulse dac_set → three write frames with SDIO bit streams 0x0512, 0x0634, 0x0756. Each frame has CSN low for exactly 136 cycles and CSN high ≥8 cycles between frames. CFG_DONE=1, CFG_BUSY=0, TBL_IDX=2.
- Verify pass: entry 0x8A5C (address 0x0A, data 0x5C, verify=1). DAC model returns 0x5C on SDO → write frame 0x0A5C, then read frame 0x8A00. CFG_DONE=1, CFG_ERR=0.
- Verify retry then pass: model returns 0x00 on the first read and 0x5C on the second → exactly 2 write and 2 read frames for the entry, then CFG_DONE=1.
- Verify error: model always returns 0xFF for the entry at index 1, MAX_RETRY=2 → 3 write and 3 read frames for that entry, then CFG_ERR=1, ERR_IDX=1, CFG_DONE=0, CSN high.
- Start handling: dac_set held high for 1000 cycles → exactly one sequence. A second rising edge while busy → ignored. A rising edge after DONE → flags cleared, and the sequence repeats from index 0.
- Reset mid-frame: assert SYS_RST at bit 9 of a write frame → CSN=1 and SCLK=0 asynchronously; all status outputs at reset values. After release, no SPI activity until the next dac_set edge.
